// File: rtl/dfe_pkg.sv
// Shared types and helpers for the PAM-N decision feedback equaliser.
package dfe_pkg;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  function automatic longint sat(input longint v, input int w);
    longint mx, mn;
    mx = (longint'(1) <<< (w - 1)) - 1;
    mn = -mx - 1;
    if (v > mx) return mx;
    if (v < mn) return mn;
    return v;
  endfunction

  // L_k = (2k-(N-1))*SEP/2; SEP is even so the division is exact
  function automatic longint level(input int k, input int n, input int sep);
    return longint'(2 * k - (n - 1)) * longint'(sep) / 2;
  endfunction

  function automatic longint thresh(input int j, input int n, input int sep);
    return longint'(2 * j - (n - 2)) * longint'(sep) / 2;
  endfunction

  function automatic int acc_width(input int dw, input int cw, input int nt);
    return dw + cw + $clog2(nt) + 1;
  endfunction

endpackage

// File: rtl/dfe_pamn_slicer.sv
// Combinational PAM-N slicer: threshold count -> symbol, level and saturated error.
module dfe_pamn_slicer
  import dfe_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int PAM_LEVELS = 4,
  parameter int SYM_SEP    = 512,
  parameter int SYM_W      = $clog2(PAM_LEVELS)
) (
  input  logic signed [DATA_W-1:0] eq_i,
  output logic [SYM_W-1:0]         sym_o,
  output logic [DATA_W-1:0]        level_o,
  output logic [DATA_W-1:0]        err_o
);

  int     k;
  longint lvl;

  // ties land on the upper level because the compare is >=
  always_comb begin
    k = 0;
    for (int j = 0; j < PAM_LEVELS - 1; j++)
      if (longint'(eq_i) >= thresh(j, PAM_LEVELS, SYM_SEP)) k = k + 1;
    lvl     = level(k, PAM_LEVELS, SYM_SEP);
    sym_o   = SYM_W'(k);
    level_o = DATA_W'(lvl);
    err_o   = DATA_W'(sat(longint'(eq_i) - lvl, DATA_W));
  end

endmodule

// File: rtl/dfe_pamn.sv
// PAM-N DFE top: FSM, tap registers, decision history, MAC and output register.
module dfe_pamn
  import dfe_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int NTAPS      = 8,
  parameter int PAM_LEVELS = 4,
  parameter int SYM_SEP    = 512,
  parameter int COEF_W     = 16,
  parameter int FRAC_BITS  = 8
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          enable,
  input  logic                          bypass,
  input  logic                          flush,
  input  logic                          coef_we,
  input  logic [$clog2(NTAPS)-1:0]      coef_addr,
  input  logic [COEF_W-1:0]             coef_wdata,
  input  logic [DATA_W-1:0]             in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [$clog2(PAM_LEVELS)-1:0] out_sym,
  output logic [DATA_W-1:0]             out_level,
  output logic [DATA_W-1:0]             out_err,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [31:0]                   sym_count
);

  localparam int SYM_W  = $clog2(PAM_LEVELS);
  localparam int ACC_W  = acc_width(DATA_W, COEF_W, NTAPS);
  localparam int PROD_W = DATA_W + COEF_W;

  state_t                         state_q;
  logic [NTAPS-1:0][COEF_W-1:0]   taps_q;
  logic [NTAPS-1:0][DATA_W-1:0]   hist_q;
  logic [31:0]                    cnt_q, cnt_d;
  logic                           out_valid_q;
  logic [SYM_W-1:0]               out_sym_q;
  logic [DATA_W-1:0]              out_level_q, out_err_q;

  logic                           accept;
  logic signed [PROD_W-1:0]       prod [NTAPS];
  logic signed [ACC_W-1:0]        acc, isi, isi_m;
  logic signed [ACC_W:0]          diff;
  logic signed [DATA_W-1:0]       eq;
  logic [SYM_W-1:0]               sl_sym;
  logic [DATA_W-1:0]              sl_level, sl_err;

  assign in_ready = (state_q == RUN) & (~out_valid_q | out_ready);
  assign accept   = in_valid & in_ready;

  always_comb begin
    acc = '0;
    for (int j = 0; j < NTAPS; j++) begin
      prod[j] = PROD_W'($signed(taps_q[j])) * PROD_W'($signed(hist_q[j]));
      acc     = acc + ACC_W'(prod[j]);
    end
  end

  // floor shift; bypass drops the ISI term but history keeps updating
  assign isi   = acc >>> FRAC_BITS;
  assign isi_m = bypass ? '0 : isi;
  assign diff  = (ACC_W+1)'($signed(in_data)) - (ACC_W+1)'(isi_m);
  assign eq    = DATA_W'(sat(longint'(diff), DATA_W));

  dfe_pamn_slicer #(
    .DATA_W(DATA_W), .PAM_LEVELS(PAM_LEVELS), .SYM_SEP(SYM_SEP), .SYM_W(SYM_W)
  ) u_slicer (
    .eq_i(eq), .sym_o(sl_sym), .level_o(sl_level), .err_o(sl_err)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else if (flush) state_q <= FLUSH;
    else begin
      case (state_q)
        IDLE:    if (enable) state_q <= RUN;
        RUN:     if (!enable) state_q <= IDLE;
        default: state_q <= enable ? RUN : IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == FLUSH) cnt_d = '0;
    else if (accept)      cnt_d = cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      taps_q      <= '0;
      hist_q      <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_sym_q   <= '0;
      out_level_q <= '0;
      out_err_q   <= '0;
    end else begin
      // the accept in this cycle already used the old tap via taps_q
      if (coef_we && (32'(coef_addr) < NTAPS)) taps_q[coef_addr] <= coef_wdata;
      cnt_q <= cnt_d;
      if (state_q == FLUSH) hist_q <= '0;
      else if (accept)      hist_q <= {hist_q[NTAPS-2:0], sl_level};
      if (accept) begin
        out_valid_q <= 1'b1;
        out_sym_q   <= sl_sym;
        out_level_q <= sl_level;
        out_err_q   <= sl_err;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_sym   = out_sym_q;
  assign out_level = out_level_q;
  assign out_err   = out_err_q;
  assign sym_count = cnt_q;

endmodule

// File: tb/tb_dfe_pamn.sv
// Scoreboard bench for dfe_pamn (16-bit, 8 taps, PAM-4, SEP 512, 8 fractional bits).
module tb_dfe_pamn;

  logic               clk = 1'b0;
  logic               rstn = 1'b0;
  logic               enable = 1'b0, bypass = 1'b0, flush = 1'b0, coef_we = 1'b0;
  logic [2:0]         coef_addr = '0;
  logic signed [15:0] coef_wdata = '0;
  logic signed [15:0] in_data = '0;
  logic               in_valid = 1'b0, in_ready;
  logic [1:0]         out_sym;
  logic signed [15:0] out_level, out_err;
  logic               out_valid, out_ready = 1'b1;
  logic [31:0]        sym_count;

  typedef struct { longint sym; longint lvl; longint err; } exp_t;
  exp_t   sbq[$];
  longint m_tap[8];
  longint m_hist[8];
  longint m_cnt;
  int     n_chk = 0, n_fail = 0;

  dfe_pamn dut (
    .clk(clk), .rstn(rstn), .enable(enable), .bypass(bypass), .flush(flush),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_sym(out_sym), .out_level(out_level), .out_err(out_err),
    .out_valid(out_valid), .out_ready(out_ready), .sym_count(sym_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint clamp16(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  // PAM-4 reference: levels -768,-256,256,768, decision boundaries -512,0,512
  function automatic exp_t model(input longint din, input bit byp);
    longint acc, eq;
    exp_t   e;
    acc = 0;
    for (int j = 0; j < 8; j++) acc += m_tap[j] * m_hist[j];
    eq = clamp16(din - (byp ? 0 : (acc >>> 8)));
    if (eq < -512)   e.sym = 0;
    else if (eq < 0) e.sym = 1;
    else if (eq < 512) e.sym = 2;
    else             e.sym = 3;
    e.lvl = -768 + 512 * e.sym;
    e.err = clamp16(eq - e.lvl);
    return e;
  endfunction

  always @(negedge clk) begin : mon
    exp_t e;
    if (rstn) begin
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) chk("sb_underflow", 1, 0);
        else begin
          e = sbq.pop_front();
          chk("sb_sym", out_sym, e.sym);
          chk("sb_level", out_level, e.lvl);
          chk("sb_err", out_err, e.err);
        end
      end
      if (in_valid && in_ready) begin
        e = model(in_data, bypass);
        sbq.push_back(e);
        for (int j = 7; j > 0; j--) m_hist[j] = m_hist[j-1];
        m_hist[0] = e.lvl;
        m_cnt++;
      end
      if (coef_we) m_tap[coef_addr] = coef_wdata;
      if (flush) begin
        for (int j = 0; j < 8; j++) m_hist[j] = 0;
        m_cnt = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send(input longint d);
    bit ok;
    ok = 1'b0;
    in_data  = 16'(d);
    in_valid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
    end
    if (!ok) chk("accept_timeout", 0, 1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic send_chk(input longint d, input longint s, input longint l, input longint e);
    send(d);
    @(negedge clk);
    chk("out_valid", out_valid, 1);
    chk("out_sym", out_sym, s);
    chk("out_level", out_level, l);
    chk("out_err", out_err, e);
    step();
  endtask

  task automatic wr_coef(input int a, input longint v);
    coef_addr  = 3'(a);
    coef_wdata = 16'(v);
    coef_we    = 1'b1;
    step();
    coef_we = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
    @(negedge clk);
    chk("flush_in_ready", in_ready, 0);
    step();
  endtask

  initial begin
    for (int j = 0; j < 8; j++) begin m_tap[j] = 0; m_hist[j] = 0; end
    m_cnt = 0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_count", sym_count, 0);
    chk("rst_level", out_level, 0);
    step();
    rstn = 1'b1; enable = 1'b1;
    step(); step();

    // zero taps: plain slicing, tie at 512 goes up
    send_chk(300, 2, 256, 44);
    send_chk(512, 3, 768, -256);
    send_chk(-1000, 0, -768, -232);
    chk("count_3", sym_count, 3);
    do_flush();
    chk("count_flush", sym_count, 0);

    // h[1] = 0.5
    wr_coef(0, 128);
    send_chk(768, 3, 768, 0);
    send_chk(1152, 3, 768, 0);
    bypass = 1'b1;
    send_chk(1152, 3, 768, 384);
    bypass = 1'b0;

    // backpressure: one accept, then three stalled cycles with the next sample waiting
    out_ready = 1'b0; in_data = 100; in_valid = 1'b1;
    @(negedge clk);
    chk("bp_first_ready", in_ready, 1);
    step();
    in_data = 200;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_valid", out_valid, 1);
      chk("bp_sym", out_sym, 1);
      chk("bp_level", out_level, -256);
      chk("bp_err", out_err, -28);
      chk("bp_count", sym_count, 4);
      step();
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_resume_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp2_sym", out_sym, 2);
    chk("bp2_err", out_err, 72);
    chk("bp2_count", sym_count, 5);
    step();

    // saturation
    do_flush();
    send_chk(768, 3, 768, 0);
    wr_coef(0, -32768);
    send_chk(32767, 3, 768, 31999);

    // flush with a beat pending
    wr_coef(0, 128);
    out_ready = 1'b0;
    send(768);
    flush = 1'b1;
    step();
    flush = 1'b0;
    @(negedge clk);
    chk("fl_in_ready", in_ready, 0);
    chk("fl_pending", out_valid, 1);
    step();
    out_ready = 1'b1;
    step();
    send_chk(256, 2, 256, 0);
    chk("fl_count", sym_count, 1);

    // random traffic against the model
    for (int a = 0; a < 8; a++) wr_coef(a, longint'($urandom_range(0, 128)) - 64);
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 16'(int'($urandom_range(0, 4000)) - 2000);
      out_ready = ($urandom_range(0, 3) != 0);
      bypass    = ($urandom_range(0, 15) == 0);
      flush     = ($urandom_range(0, 39) == 0);
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1; bypass = 1'b0; flush = 1'b0;
    step(); step();
    chk("rand_count", sym_count, m_cnt);

    // enable drop: last accept happens, then intake stops and output drains
    in_valid = 1'b1; in_data = 0; enable = 1'b0;
    @(negedge clk);
    chk("en_last_ready", in_ready, 1);
    step();
    @(negedge clk);
    chk("en_idle_ready", in_ready, 0);
    in_valid = 1'b0;
    step();
    @(negedge clk);
    chk("en_drained", out_valid, 0);
    step();

    // asynchronous reset with a beat pending
    enable = 1'b1;
    step(); step();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 500;
    step(); step();
    rstn = 1'b0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_ready", in_ready, 0);
    chk("arst_count", sym_count, 0);
    sbq.delete();
    for (int j = 0; j < 8; j++) begin m_tap[j] = 0; m_hist[j] = 0; end
    m_cnt = 0;
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    rstn = 1'b1;
    step(); step();
    send_chk(300, 2, 256, 44);

    step();
    chk("sb_empty", sbq.size(), 0);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
